mem_arbiter_ctrl: RTL and testbench
===================================

Name: mem_arbiter_ctrl

Overview:
- Sole owner of the 8-bit unified RAM port.
- Arbitrates two requesters: instruction fetch (32-bit word reads) and the load/store buffer (1/2/4-byte loads and stores).
- Sequences each request into little-endian byte transfers and returns assembled data with a one-cycle done pulse.
- Handles pipeline flush and the UART-full stall on the I/O address.

Parameters:
- IO_ADDR, 32'h0003_0000, byte address of the UART write port; stores to it stall while io_buffer_full=1.
- RAM_LAT, 1, RAM read latency in cycles (address edge to data-valid edge); only 1 is required.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; when 0 all state holds
- clr_in  in  1  pipeline flush
- io_buffer_full  in  1  UART FIFO full
- mem_din  in  8  RAM read data
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1=write, 0=read
- if_to_mc_ready  in  1  fetch request level
- if_to_mc_addr  in  32  fetch word address
- mc_to_if_done  out  1  fetch done pulse
- mc_to_if_data  out  32  fetched word
- lsb_to_mc_ready  in  1  LSB request level
- lsb_to_mc_len  in  2  01=1B, 10=2B, 11=4B; 00 is illegal
- lsb_to_mc_opType  in  OP_TYPE  store type code means write, otherwise read
- lsb_to_mc_addr  in  32  byte address
- lsb_to_mc_data  in  32  store data, low bytes used
- mc_valid  out  1  one-cycle pulse: LSB request accepted
- mc_to_lsb_ld_done  out  1  load done pulse
- mc_to_lsb_st_done  out  1  store done pulse
- mc_to_lsb_result  out  32  load data, zero-extended

Behaviour:
- All outputs are registered.
- Reset values: mem_a=0, mem_dout=0, mem_wr=0, all done pulses=0, mc_valid=0, data outputs=0, state=IDLE, cnt=0. Reset mid-transfer discards the transfer with no done pulse.
- States: IDLE, FETCH, LOAD, STORE. A 3-bit byte counter `cnt` and a length N (fetch N=4).
- IDLE arbitration at edge t:
  - lsb_to_mc_ready has priority over fetch; LSB requests are commit-ordered.
  - LSB accept: mc_valid=1 for that cycle only; latch addr, data and N; enter LOAD or STORE.
  - Else if if_to_mc_ready: enter FETCH.
  - The same edge drives mem_a=addr for byte 0 (and for stores, mem_wr=1, mem_dout=byte 0).
- Read sequencing (LOAD/FETCH):
  - Byte k address is driven at edge t+k.
  - mem_din for byte k is sampled at edge t+k+1 into result bits [8k+7:8k].
  - mem_wr=0 throughout.
  - At edge t+N the last byte is merged; the done pulse and data are registered one edge later, at t+N+1, high for exactly 1 cycle.
  - Unused upper result bytes are 0.
  - Return to IDLE with mem_a=0. The next request may be accepted at edge t+N+2.
- Store sequencing:
  - Byte k is driven at edge t+k with mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k].
  - Stall: if the target address == IO_ADDR and io_buffer_full=1, drive mem_wr=0 and hold cnt. The byte is retried each cycle until io_buffer_full=0.
  - After the last byte, mem_wr=0; st_done is pulsed 1 cycle at the following edge, then IDLE.
- Address arithmetic is 32-bit wrap. No alignment requirement; misaligned multi-byte access is sequenced normally.
- clr_in:
  - In FETCH or LOAD: abort immediately. mem_wr=0, no done pulse, next state IDLE.
  - In STORE: ignored. The store has already committed and completes, including st_done.
  - In IDLE, clr_in has priority over a same-cycle fetch request (no accept). An LSB store request in the same cycle is still accepted.
- rdy_in=0 freezes the state, counters and all outputs. Done pulses do not repeat.
- A requester holds ready and address stable until its done pulse or clr. A fetch request that arrives while the LSB is served waits (no starvation guarantee beyond LSB being idle).

Test Plan:
- Fetch addr 0x100, RAM bytes 13,00,00,00 -> mc_to_if_done high exactly 5 cycles after accept, data 0x00000013, mem_wr stays 0.
- LSB LW addr 0x200 and fetch 0x104 asserted in the same cycle -> mc_valid on the first edge, LSB served first, ld_done then the fetch done, no overlap.
- LSB SH data 0xDEADBEEF to 0x300 -> writes EF@0x300, BE@0x301, then st_done 1 cycle; RAM[0x302] untouched.
- SB 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for 3 cycles, then a single write of 0x41, then st_done.
- clr_in during the second byte of a fetch -> no mc_to_if_done, IDLE next cycle; clr_in mid-SW -> all 4 bytes written and st_done still pulses.
- rst_in asserted mid-LW -> all outputs 0 the next cycle, no ld_done; a new LB afterward returns the correct zero-extended byte.

Source files
------------

// File: rtl/mem_arbiter_ctrl_if.sv
// mem_arbiter_ctrl_if: unified RAM byte port plus fetch and load/store requester channels
interface mem_arbiter_ctrl_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_to_mc_ready;
  logic [31:0] if_to_mc_addr;
  logic        mc_to_if_done;
  logic [31:0] mc_to_if_data;
  logic        lsb_to_mc_ready;
  logic [1:0]  lsb_to_mc_len;
  logic [3:0]  lsb_to_mc_opType;
  logic [31:0] lsb_to_mc_addr;
  logic [31:0] lsb_to_mc_data;
  logic        mc_valid;
  logic        mc_to_lsb_ld_done;
  logic        mc_to_lsb_st_done;
  logic [31:0] mc_to_lsb_result;
  modport master (
    input  mem_din, if_to_mc_ready, if_to_mc_addr,
           lsb_to_mc_ready, lsb_to_mc_len, lsb_to_mc_opType, lsb_to_mc_addr, lsb_to_mc_data,
    output mem_dout, mem_a, mem_wr, mc_to_if_done, mc_to_if_data,
           mc_valid, mc_to_lsb_ld_done, mc_to_lsb_st_done, mc_to_lsb_result
  );
  modport slave (
    output mem_din, if_to_mc_ready, if_to_mc_addr,
           lsb_to_mc_ready, lsb_to_mc_len, lsb_to_mc_opType, lsb_to_mc_addr, lsb_to_mc_data,
    input  mem_dout, mem_a, mem_wr, mc_to_if_done, mc_to_if_data,
           mc_valid, mc_to_lsb_ld_done, mc_to_lsb_st_done, mc_to_lsb_result
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: arbitrates fetch and load/store requests onto an 8-bit RAM port
module mem_arbiter_ctrl #(
  parameter logic [31:0] IO_ADDR  = 32'h0003_0000,
  parameter int          RAM_LAT  = 1,
  parameter logic [3:0]  OP_STORE = 4'h2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic clr_in,
  input  logic io_buffer_full,
  mem_arbiter_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
  localparam logic [2:0] LAT = 3'(RAM_LAT);
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, n_q, n_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d, valid_q, valid_d;
  logic        ld_done_q, ld_done_d, st_done_q, st_done_d;
  logic [31:0] if_data_q, if_data_d, result_q, result_d;
  logic        lsb_st;
  logic [2:0]  lsb_n;
  logic [31:0] st_addr;
  assign lsb_st  = bus.lsb_to_mc_opType == OP_STORE;
  assign lsb_n   = bus.lsb_to_mc_len == 2'd3 ? 3'd4 : bus.lsb_to_mc_len == 2'd0 ? 3'd1 : {1'b0, bus.lsb_to_mc_len};
  assign st_addr = addr_q + {29'b0, cnt_q};
  function automatic logic io_stall(input logic [31:0] a, input logic full);
    return a == IO_ADDR && full;
  endfunction
  // arbitration, byte sequencing and next values of every registered output
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    addr_d     = addr_q;
    data_d     = data_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    valid_d    = 1'b0;
    ld_done_d  = 1'b0;
    st_done_d  = 1'b0;
    if_data_d  = if_data_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (bus.lsb_to_mc_ready && (!clr_in || lsb_st)) begin
          state_d    = lsb_st ? STORE : LOAD;
          valid_d    = 1'b1;
          addr_d     = bus.lsb_to_mc_addr;
          data_d     = bus.lsb_to_mc_data;
          n_d        = lsb_n;
          buf_d      = '0;
          mem_a_d    = bus.lsb_to_mc_addr;
          mem_dout_d = lsb_st ? bus.lsb_to_mc_data[7:0] : 8'h00;
          mem_wr_d   = lsb_st && !io_stall(bus.lsb_to_mc_addr, io_buffer_full);
          cnt_d      = (lsb_st && !mem_wr_d) ? 3'd0 : 3'd1;
        end else if (bus.if_to_mc_ready && !clr_in) begin
          state_d    = FETCH;
          addr_d     = bus.if_to_mc_addr;
          n_d        = 3'd4;
          buf_d      = '0;
          mem_a_d    = bus.if_to_mc_addr;
          mem_dout_d = 8'h00;
          cnt_d      = 3'd1;
        end
      end
      FETCH, LOAD: begin
        if (clr_in) begin
          state_d = IDLE;
          cnt_d   = '0;
          mem_a_d = '0;
        end else if (cnt_q == n_q + LAT) begin
          state_d   = IDLE;
          cnt_d     = '0;
          if_done_d = state_q == FETCH;
          ld_done_d = state_q == LOAD;
          if_data_d = state_q == FETCH ? buf_q : if_data_q;
          result_d  = state_q == LOAD ? buf_q : result_q;
        end else begin
          for (int k = 0; k < 4; k++)
            if (cnt_q == 3'(k) + LAT) buf_d[8*k +: 8] = bus.mem_din;
          cnt_d   = cnt_q + 3'd1;
          mem_a_d = cnt_q < n_q ? addr_q + {29'b0, cnt_q} : '0;
        end
      end
      STORE: begin
        if (cnt_q == n_q) begin
          state_d    = IDLE;
          cnt_d      = '0;
          st_done_d  = 1'b1;
          mem_a_d    = '0;
          mem_dout_d = 8'h00;
        end else begin
          mem_a_d = st_addr;
          for (int k = 0; k < 4; k++)
            if (cnt_q[1:0] == 2'(k)) mem_dout_d = data_q[8*k +: 8];
          mem_wr_d = !io_stall(st_addr, io_buffer_full);
          cnt_d    = mem_wr_d ? cnt_q + 3'd1 : cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; rdy_in low holds everything in place
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      valid_q    <= 1'b0;
      ld_done_q  <= 1'b0;
      st_done_q  <= 1'b0;
      if_data_q  <= '0;
      result_q   <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      valid_q    <= valid_d;
      ld_done_q  <= ld_done_d;
      st_done_q  <= st_done_d;
      if_data_q  <= if_data_d;
      result_q   <= result_d;
    end
  end
  assign bus.mem_a             = mem_a_q;
  assign bus.mem_dout          = mem_dout_q;
  assign bus.mem_wr            = mem_wr_q;
  assign bus.mc_to_if_done     = if_done_q;
  assign bus.mc_to_if_data     = if_data_q;
  assign bus.mc_valid          = valid_q;
  assign bus.mc_to_lsb_ld_done = ld_done_q;
  assign bus.mc_to_lsb_st_done = st_done_q;
  assign bus.mc_to_lsb_result  = result_q;
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: scoreboard bench for the RAM arbiter with a byte RAM model
module tb_mem_arbiter_ctrl;
  localparam logic [3:0] OP_LD = 4'h1;
  localparam logic [3:0] OP_ST = 4'h2;
  typedef struct packed {
    int unsigned cyc;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;
  logic clk = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, clr_in = 1'b0, io_buffer_full = 1'b0;
  int unsigned cyc = 0;
  int total = 0, bad = 0;
  logic [7:0] ram [logic [31:0]];
  int unsigned v_q[$];
  int unsigned st_q[$];
  exp_t if_q[$];
  exp_t ld_q[$];
  exp_t wr_q[$];
  exp_t me;
  mem_arbiter_ctrl_if b();
  mem_arbiter_ctrl dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .io_buffer_full(io_buffer_full), .bus(b.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // RAM: address seen during a cycle returns data before the next rising edge
  always @(negedge clk) begin
    if (b.mem_wr) ram[b.mem_a] = b.mem_dout;
    b.mem_din = ram.exists(b.mem_a) ? ram[b.mem_a] : 8'h00;
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", n, act, exp, cyc);
    end
  endtask
  task automatic extra(input string n);
    total++;
    bad++;
    $display("FAIL %s unexpected event at cycle %0d", n, cyc);
  endtask
  // monitor: pops an expectation whenever the DUT presents an event
  always @(negedge clk) if (!rst_in) begin
    if (b.mc_valid) begin
      if (v_q.size() == 0) extra("mc_valid");
      else chk("valid_cyc", 64'(cyc), 64'(v_q.pop_front()));
    end
    if (b.mc_to_if_done) begin
      if (if_q.size() == 0) extra("if_done");
      else begin
        me = if_q.pop_front();
        chk("if_cyc", 64'(cyc), 64'(me.cyc));
        chk("if_data", 64'(b.mc_to_if_data), 64'(me.d));
      end
    end
    if (b.mc_to_lsb_ld_done) begin
      if (ld_q.size() == 0) extra("ld_done");
      else begin
        me = ld_q.pop_front();
        chk("ld_cyc", 64'(cyc), 64'(me.cyc));
        chk("ld_data", 64'(b.mc_to_lsb_result), 64'(me.d));
      end
    end
    if (b.mc_to_lsb_st_done) begin
      if (st_q.size() == 0) extra("st_done");
      else chk("st_cyc", 64'(cyc), 64'(st_q.pop_front()));
    end
    if (b.mem_wr) begin
      if (wr_q.size() == 0) extra("mem_wr");
      else begin
        me = wr_q.pop_front();
        chk("wr_cyc", 64'(cyc), 64'(me.cyc));
        chk("wr_addr", 64'(b.mem_a), 64'(me.a));
        chk("wr_data", 64'(b.mem_dout), 64'(me.d[7:0]));
      end
    end
  end
  task automatic fetch_op(input logic [31:0] a, input logic [31:0] exp_d, input int delay);
    int unsigned t = cyc + 1 + delay;
    int i = 0;
    b.if_to_mc_ready = 1'b1;
    b.if_to_mc_addr  = a;
    if_q.push_back('{cyc: t + 5, a: a, d: exp_d});
    do begin @(negedge clk); i++; end while (!b.mc_to_if_done && i < 60);
    if (!b.mc_to_if_done) begin total++; bad++; $display("FAIL fetch_timeout addr=%h", a); end
    b.if_to_mc_ready = 1'b0;
  endtask
  task automatic lsb_op(input logic [31:0] a, input logic [1:0] len, input logic st,
                        input logic [31:0] d, input logic [31:0] exp_r, input int stall);
    int n = (len == 2'd3) ? 4 : int'(len);
    int unsigned t = cyc + 1;
    int i = 0;
    logic hit;
    b.lsb_to_mc_ready  = 1'b1;
    b.lsb_to_mc_addr   = a;
    b.lsb_to_mc_len    = len;
    b.lsb_to_mc_opType = st ? OP_ST : OP_LD;
    b.lsb_to_mc_data   = d;
    io_buffer_full     = stall > 0;
    v_q.push_back(t);
    if (st) begin
      for (int k = 0; k < n; k++)
        wr_q.push_back('{cyc: t + stall + k, a: a + 32'(k), d: {24'b0, d[8*k +: 8]}});
      st_q.push_back(t + stall + n);
    end else ld_q.push_back('{cyc: t + n + 1, a: a, d: exp_r});
    repeat (stall) @(negedge clk);
    io_buffer_full = 1'b0;
    do begin
      @(negedge clk);
      i++;
      hit = st ? b.mc_to_lsb_st_done : b.mc_to_lsb_ld_done;
    end while (!hit && i < 60);
    if (!hit) begin total++; bad++; $display("FAIL lsb_timeout addr=%h", a); end
    b.lsb_to_mc_ready = 1'b0;
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_bus"}, 64'({b.mem_a, b.mem_dout, b.mem_wr}), 64'(0));
    chk({n, "_pulses"}, 64'({b.mc_valid, b.mc_to_if_done, b.mc_to_lsb_ld_done, b.mc_to_lsb_st_done}), 64'(0));
    chk({n, "_data"}, {b.mc_to_if_data, b.mc_to_lsb_result}, 64'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    b.if_to_mc_ready = 1'b0; b.if_to_mc_addr = '0;
    b.lsb_to_mc_ready = 1'b0; b.lsb_to_mc_len = 2'd0; b.lsb_to_mc_opType = OP_LD;
    b.lsb_to_mc_addr = '0; b.lsb_to_mc_data = '0; b.mem_din = 8'h00;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h104] = 8'h93; ram[32'h105] = 8'h02; ram[32'h106] = 8'h10; ram[32'h107] = 8'h00;
    ram[32'h200] = 8'h78; ram[32'h201] = 8'h56; ram[32'h202] = 8'h34; ram[32'h203] = 8'h12;
    ram[32'h302] = 8'h77;
    ram[32'h500] = 8'hC3; ram[32'h505] = 8'hA5; ram[32'h506] = 8'hFF;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_in = 1'b0;
    @(negedge clk);
    fetch_op(32'h100, 32'h0000_0013, 0);
    fork
      lsb_op(32'h200, 2'd3, 1'b0, 32'h0, 32'h1234_5678, 0);
      fetch_op(32'h104, 32'h0010_0293, 6);
    join
    lsb_op(32'h300, 2'd2, 1'b1, 32'hDEAD_BEEF, 32'h0, 0);
    chk("ram_302_kept", 64'(ram[32'h302]), 64'(8'h77));
    lsb_op(32'h300, 2'd3, 1'b0, 32'h0, 32'h0077_BEEF, 0);
    lsb_op(32'h201, 2'd2, 1'b0, 32'h0, 32'h0000_3456, 0);
    lsb_op(32'h0003_0000, 2'd1, 1'b1, 32'h0000_0041, 32'h0, 3);
    chk("ram_io", 64'(ram[32'h0003_0000]), 64'(8'h41));
    b.if_to_mc_ready = 1'b1;
    b.if_to_mc_addr  = 32'h100;
    @(negedge clk);
    @(negedge clk);
    chk("clr_byte1_addr", 64'(b.mem_a), 64'(32'h101));
    clr_in = 1'b1;
    b.if_to_mc_ready = 1'b0;
    @(negedge clk);
    clr_in = 1'b0;
    chk("clr_idle_bus", 64'({b.mem_a, b.mem_wr}), 64'(0));
    repeat (6) @(negedge clk);
    fetch_op(32'h104, 32'h0010_0293, 0);
    fork
      lsb_op(32'h400, 2'd3, 1'b1, 32'h1122_3344, 32'h0, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        clr_in = 1'b1;
        @(negedge clk);
        clr_in = 1'b0;
      end
    join
    lsb_op(32'h400, 2'd3, 1'b0, 32'h0, 32'h1122_3344, 0);
    b.lsb_to_mc_ready  = 1'b1;
    b.lsb_to_mc_addr   = 32'h500;
    b.lsb_to_mc_len    = 2'd3;
    b.lsb_to_mc_opType = OP_LD;
    v_q.push_back(cyc + 1);
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b1;
    b.lsb_to_mc_ready = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    rst_in = 1'b0;
    @(negedge clk);
    lsb_op(32'h505, 2'd1, 1'b0, 32'h0, 32'h0000_00A5, 0);
    repeat (8) @(negedge clk);
    chk("leftover", 64'(v_q.size() + st_q.size() + if_q.size() + ld_q.size() + wr_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
